vpu_req_arbiter: RTL and testbench

//  Shares the single vector unit (VPU) between NUM_REQ instruction requesters (host, DMA, sequencers).

---
 rtl/vpu_pkg.sv | 24 ++
 rtl/vpu_rr_pick.sv | 32 +++
 rtl/vpu_req_arbiter.sv | 134 +++++++++++++
 tb/tb_vpu_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU definitions: instruction layout, arbiter state encoding, constants.
package vpu_pkg;

   localparam int unsigned OP_W = 8;
   localparam int unsigned FIELD_W = 6;
   // Host-map address of the VPU instruction port
   localparam logic [15:0] INST_ADDR = 16'h0040;

   typedef struct packed {
      logic [OP_W-1:0]    opcode;
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] b;
      logic [FIELD_W-1:0] c;
      logic [FIELD_W-1:0] imm;
   } inst_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StRetire
   } arb_state_t;

endpackage

// File: rtl/vpu_rr_pick.sv
// Round-robin pick: first valid requester strictly after rr_ptr, wrapping.
module vpu_rr_pick
   import vpu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   // Scan NUM_REQ positions starting one past the pointer; first hit wins
   always_comb begin
      int unsigned j;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!any && req_valid[IDX_W'(j)]) begin
            any                  = 1'b1;
            grant[IDX_W'(j)]     = 1'b1;
            grant_idx            = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter sharing one VPU between NUM_REQ requesters, one instruction in flight.
// Optional WAIT watchdog enabled by defining VPU_ARB_TIMEOUT_EN.
module vpu_req_arbiter
   import vpu_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned INST_W    = $bits(inst_t),
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0][INST_W-1:0] req_inst,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          req_err,
   output logic [INST_W-1:0]             vpu_inst,
   output logic                          vpu_start,
   input  logic                          vpu_done,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t          state_q, state_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [IDX_W-1:0]    gid_q, gid_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic                tmo_hit;

   vpu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

`ifdef VPU_ARB_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TmoLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic                 err_q, err_d;

   // Terminal WAIT cycle: the counter reaches all-ones on this cycle's increment
   assign tmo_hit = (state_q == StWait) && (tmo_q == TmoLast);

   // Watchdog counter and abort flag; vpu_done on the terminal cycle wins
   always_comb begin
      tmo_d = tmo_q;
      err_d = err_q;
      if (state_q == StIssue) begin
         tmo_d = '0;
         err_d = 1'b0;
      end else if (state_q == StWait) begin
         tmo_d = tmo_q + 1'b1;
         err_d = tmo_hit && !vpu_done;
      end
   end

   // Watchdog state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign req_err = (state_q == StRetire) && err_q;
`else
   assign tmo_hit = 1'b0;
   assign req_err = 1'b0;
`endif

   // Next-state, instruction latch, owner and round-robin pointer
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      gid_d   = gid_q;
      rr_d    = rr_q;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               inst_d  = req_inst[pick_idx];
               gid_d   = pick_idx;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (vpu_done || tmo_hit) state_d = StRetire;
         end
         StRetire: begin
            rr_d    = gid_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         inst_q  <= '0;
         gid_q   <= '0;
         rr_q    <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         gid_q   <= gid_d;
         rr_q    <= rr_d;
      end
   end

   // Ready is gated by rst so it reads 0 during an asynchronous reset
   assign req_ready = ((state_q == StIdle) && !rst) ? pick_grant : '0;
   assign req_done  = (state_q == StRetire) ? (NUM_REQ'(1) << gid_q) : '0;
   assign vpu_start = (state_q == StIssue);
   assign busy      = (state_q != StIdle);
   assign vpu_inst  = inst_q;
   assign grant_id  = gid_q;

endmodule

// File: tb/tb_vpu_req_arbiter.sv
// Randomized bench for vpu_req_arbiter against a cycle-count transaction model.
// Timeout scenarios are exercised when VPU_ARB_TIMEOUT_EN is defined.
module tb_vpu_req_arbiter;
   import vpu_pkg::*;

   localparam int N  = 4;
   localparam int IW = 32;
`ifdef VPU_ARB_TIMEOUT_EN
   localparam int TW        = 4;
   localparam int TMO_WAITS = 15;
`else
   localparam int TW        = 8;
   localparam int TMO_WAITS = 0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N-1:0]            req_valid;
   logic [N-1:0][IW-1:0]    req_inst;
   logic [N-1:0]            req_ready;
   logic [N-1:0]            req_done;
   logic                    req_err;
   logic [IW-1:0]           vpu_inst;
   logic                    vpu_start;
   logic                    vpu_done;
   logic                    busy;
   logic [1:0]              grant_id;

   vpu_req_arbiter #(
      .NUM_REQ   (N),
      .INST_W    (IW),
      .TIMEOUT_W (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_inst  (req_inst),
      .req_ready (req_ready),
      .req_done  (req_done),
      .req_err   (req_err),
      .vpu_inst  (vpu_inst),
      .vpu_start (vpu_start),
      .vpu_done  (vpu_done),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: transaction-level view counted in cycles since the accept
   bit          m_idle;
   int          m_since;
   bit          m_retire;
   bit          m_err;
   int          m_last;
   int          m_owner;
   logic [31:0] m_inst;
   int          grants[$];
   int          last_acc;

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int j = (last + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_idle = 1; m_since = 0; m_retire = 0; m_err = 0;
      m_last = N - 1; m_owner = 0; m_inst = '0;
   endtask

   // One clock: check outputs at negedge, advance model, return 1 ns after posedge
   task automatic cyc();
      int p;
      logic [N-1:0] er, ed;
      @(negedge clk);
      p  = m_idle ? pick(req_valid, m_last) : -1;
      er = (p >= 0) ? N'(1 << p) : '0;
      ed = m_retire ? N'(1 << m_owner) : '0;
      check_eq("req_ready", req_ready, er);
      check_eq("req_done", req_done, ed);
      check_eq("req_err", req_err, m_retire && m_err);
      check_eq("vpu_start", vpu_start, !m_idle && !m_retire && m_since == 1);
      check_eq("busy", busy, !m_idle);
      check_eq("vpu_inst", vpu_inst, m_inst);
      check_eq("grant_id", grant_id, m_owner);
      last_acc = p;
      if (p >= 0) begin
         m_idle = 0; m_since = 1; m_owner = p; m_inst = req_inst[p];
         grants.push_back(p);
      end else if (m_retire) begin
         m_retire = 0; m_idle = 1; m_last = m_owner; m_err = 0;
      end else if (!m_idle) begin
         if (m_since >= 2 && vpu_done) begin
            m_retire = 1; m_err = 0;
         end else if (TMO_WAITS > 0 && m_since - 1 == TMO_WAITS) begin
            m_retire = 1; m_err = 1;
         end
         m_since++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      vpu_done  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic drain();
      req_valid = '0;
      for (int i = 0; i < 60 && !m_idle; i++) begin
         vpu_done = (m_since >= 3) && !m_retire;
         cyc();
      end
      vpu_done = 1'b0;
      check_eq("drain_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_order[5];
      int g0;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
      exp_order[3] = 3; exp_order[4] = 0;

      rst = 1'b1; req_valid = '0; req_inst = '0; vpu_done = 1'b0;
      model_reset();
      #2;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_start", vpu_start, 0);
      check_eq("rst_inst", vpu_inst, 0);
      check_eq("rst_done", req_done, 0);
      check_eq("rst_err", req_err, 0);
      check_eq("rst_gid", grant_id, 0);
      req_valid = 4'b1111;
      #1;
      check_eq("rst_ready", req_ready, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single requester, fixed latency
      req_valid = 4'b0001; req_inst[0] = 32'h0000_1232;
      cyc();
      check_eq("t1_accept", last_acc, 0);
      req_valid = '0;
      cyc();
      cyc();
      vpu_done = 1'b1;
      cyc();
      vpu_done = 1'b0;
      cyc();
      cyc();
      check_eq("t1_inst", vpu_inst, 32'h0000_1232);

      // All requesting: rotation 0,1,2,3,0
      do_reset();
      for (int i = 0; i < N; i++) req_inst[i] = 32'h1000_0000 + i;
      req_valid = 4'b1111;
      g0 = grants.size();
      for (int c = 0; c < 40 && grants.size() - g0 < 5; c++) begin
         vpu_done = !m_idle && !m_retire && m_since == 3;
         cyc();
         if (last_acc >= 0) req_inst[last_acc] = $urandom;
      end
      check_eq("t2_rounds", grants.size() - g0, 5);
      for (int i = 0; i < 5 && g0 + i < grants.size(); i++)
         check_eq("t2_order", grants[g0 + i], exp_order[i]);
      drain();

      // Inst change in WAIT, spurious done in IDLE and ISSUE
      vpu_done = 1'b1;
      cyc();
      req_valid = 4'b0100; req_inst[2] = 32'hA5A5_0002; vpu_done = 1'b0;
      cyc();
      req_valid = '0; vpu_done = 1'b1;
      cyc();
      req_inst[2] = 32'hDEAD_BEEF; vpu_done = 1'b0;
      cyc();
      cyc();
      check_eq("t3_inst_hold", vpu_inst, 32'hA5A5_0002);
      vpu_done = 1'b1;
      cyc();
      vpu_done = 1'b0;
      cyc();
      cyc();

      // Asynchronous reset mid-WAIT
      req_valid = 4'b1111;
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      check_eq("t4_busy", busy, 0);
      check_eq("t4_ready", req_ready, 0);
      check_eq("t4_done", req_done, 0);
      check_eq("t4_inst", vpu_inst, 0);
      check_eq("t4_gid", grant_id, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      req_valid = 4'b1111;
      #1;
      check_eq("t4_winner", req_ready, 4'b0001);
      cyc();
      drain();

`ifdef VPU_ARB_TIMEOUT_EN
      // Watchdog abort, then vpu_done on the terminal cycle
      req_valid = 4'b0001; req_inst[0] = 32'h0BAD_0005;
      cyc();
      req_valid = '0;
      for (int c = 0; c < 30 && !m_idle; c++) cyc();
      check_eq("t5_tmo_idle", busy, 0);
      req_valid = 4'b0001;
      cyc();
      req_valid = '0;
      for (int c = 0; c < 30 && !m_idle; c++) begin
         vpu_done = (m_since == TMO_WAITS + 1) && !m_retire;
         cyc();
      end
      vpu_done = 1'b0;
      check_eq("t5_term_idle", busy, 0);
`endif

      // Randomized traffic
      req_valid = '0;
      for (int c = 0; c < 800; c++) begin
         vpu_done = ($urandom_range(0, 3) == 0);
         cyc();
         for (int i = 0; i < N; i++) begin
            if (i == last_acc) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_inst[i]  = $urandom;
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[i] = 1'b1;
                  req_inst[i]  = $urandom;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
